// File: rtl/rv32i_types.sv
// Shared RV32I types used by the load path.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a memory word and extends it.
module load_extract
  import rv32i_types::*;
(
  input  rv32i_word   mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output rv32i_word   word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (offset)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    word = '0;
    case (funct3)
      lb:      word = {{24{w_byte[7]}}, w_byte};
      lh:      word = {{16{w_half[15]}}, w_half};
      lw:      word = mem_rdata;
      lbu:     word = {24'd0, w_byte};
      lhu:     word = {16'd0, w_half};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding RV32I load unit: checks alignment, issues one word read,
// extracts and extends the result, and holds it until the consumer takes it.
module load_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  rv32i_word   req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_read,
  output rv32i_word   mem_address,
  input  rv32i_word   mem_rdata,
  input  logic        mem_resp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output rv32i_word   rsp_data,
  output logic        rsp_error
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t      r_state, w_next_state;
  rv32i_word   r_addr, w_next_addr;
  logic [2:0]  r_funct3, w_next_funct3;
  rv32i_word   r_mem_address, w_next_mem_address;
  rv32i_word   r_rsp_data, w_next_rsp_data;
  logic        r_rsp_error, w_next_rsp_error;
  logic        r_req_ready, r_mem_read, r_rsp_valid;
  logic        w_req_err;
  rv32i_word   w_extract;

  load_extract u_extract (
    .mem_rdata (mem_rdata),
    .offset    (r_addr[1:0]),
    .funct3    (r_funct3),
    .word      (w_extract)
  );

  // Illegal funct3 or misaligned half/word access
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      lb, lbu:  w_req_err = 1'b0;
      lh, lhu:  w_req_err = req_addr[0];
      lw:       w_req_err = |req_addr[1:0];
      default:  w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state       = r_state;
    w_next_addr        = r_addr;
    w_next_funct3      = r_funct3;
    w_next_mem_address = r_mem_address;
    w_next_rsp_data    = r_rsp_data;
    w_next_rsp_error   = r_rsp_error;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_addr   = req_addr;
          w_next_funct3 = req_funct3;
          if (w_req_err) begin
            w_next_state     = RESP;
            w_next_rsp_data  = '0;
            w_next_rsp_error = 1'b1;
          end else begin
            w_next_state       = READ;
            w_next_mem_address = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ: begin
        if (mem_resp) begin
          w_next_state     = RESP;
          w_next_rsp_data  = w_extract;
          w_next_rsp_error = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are clean Moore signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_funct3      <= '0;
      r_mem_address <= '0;
      r_rsp_data    <= '0;
      r_rsp_error   <= 1'b0;
      r_req_ready   <= 1'b1;
      r_mem_read    <= 1'b0;
      r_rsp_valid   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_addr        <= w_next_addr;
      r_funct3      <= w_next_funct3;
      r_mem_address <= w_next_mem_address;
      r_rsp_data    <= w_next_rsp_data;
      r_rsp_error   <= w_next_rsp_error;
      r_req_ready   <= (w_next_state == IDLE);
      r_mem_read    <= (w_next_state == READ);
      r_rsp_valid   <= (w_next_state == RESP);
    end
  end

  assign req_ready   = r_req_ready;
  assign mem_read    = r_mem_read;
  assign mem_address = r_mem_address;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_error   = r_rsp_error;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: directed corner cases plus randomized loads
// against a byte-level reference model and a simple memory with variable delay.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_error;

  load_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_funct3  (req_funct3),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          delay;
    int          stall;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_ovr [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          quiet = 1'b0;
  bit          auto_mem = 1'b1;
  bit          force_resp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic bit ref_err(logic [31:0] a, logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      3'd2:       return a[1:0] != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

  // Shift the addressed lane down, then extend by signedness of the access.
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(off)));
    h = 16'(w >> (16 * int'(off[1])));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd2:    return w;
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [2:0] f3, input int d, input int st);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    e.addr  = a;
    e.err   = ref_err(a, f3);
    e.data  = e.err ? 32'd0 : ref_load(mem_word({a[31:2], 2'b00}), a[1:0], f3);
    e.delay = d;
    e.stall = st;
    e.acc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Memory responder: answers each read after the transaction's chosen delay,
  // and injects stray responses while no read is outstanding.
  bit pend = 1'b0;
  int cnt = 0;
  always begin
    @(posedge clk); #2;
    if (!auto_mem) begin
      mem_resp = force_resp;
    end else begin
      mem_resp  = 1'b0;
      mem_rdata = $urandom;
      if (mem_read && exp_q.size() > 0) begin
        if (!pend) begin
          pend = 1'b1;
          cnt  = exp_q[0].delay;
        end
        if (cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_word(mem_address);
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_resp = 1'b1;
      end
    end
  end

  // Consumer: stalls each response for its chosen number of cycles.
  int wait_ct = 0;
  always begin
    @(posedge clk); #2;
    if (rsp_valid && exp_q.size() > 0) begin
      if (wait_ct < exp_q[0].stall) begin
        rsp_ready = 1'b0;
        wait_ct++;
      end else begin
        rsp_ready = 1'b1;
      end
    end else begin
      wait_ct   = 0;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  bit          in_rsp = 1'b0;
  bit          post_hs = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] hold_data;
  logic        hold_err;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !quiet) begin
      if (post_hs) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        post_hs = 1'b0;
      end
      if (mem_read) begin
        if (exp_q.size() == 0) chk("read_without_req", 32'(exp_q.size()), 32'd1);
        else begin
          rd_cnt++;
          chk("mem_address", mem_address, exp_q[0].addr & 32'hFFFF_FFFC);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_without_req", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q[0];
          if (!in_rsp) begin
            in_rsp    = 1'b1;
            hold_data = rsp_data;
            hold_err  = rsp_error;
            chk("latency", 32'(cyc - e.acc), e.err ? 32'd0 : 32'(e.delay + 1));
            chk("read_cycles", 32'(rd_cnt), e.err ? 32'd0 : 32'(e.delay + 1));
          end else begin
            chk("rsp_data_stable", rsp_data, hold_data);
            chk("rsp_error_stable", 32'(rsp_error), 32'(hold_err));
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
            in_rsp  = 1'b0;
            rd_cnt  = 0;
            post_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_error", 32'(rsp_error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mem_ovr[32'h1000] = 32'h80FF_0000;
    mem_ovr[32'h2000] = 32'hBEEF_1234;
    mem_ovr[32'h4000] = 32'hCAFE_F00D;
    issue(32'h1003, 3'b000, 0, 0);
    issue(32'h2002, 3'b101, 1, 1);
    issue(32'h2002, 3'b001, 0, 0);
    issue(32'h3001, 3'b010, 0, 0);
    issue(32'h4000, 3'b010, 4, 3);
    issue(32'h0000, 3'b011, 0, 2);
    drain();

    // Reset in the middle of a read, followed by a stray late response
    quiet    = 1'b1;
    auto_mem = 1'b0;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_addr   = 32'h5000;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_reset_mem_read", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_mem_read", 32'(mem_read), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_mem_address", mem_address, 32'd0);
    rst_n      = 1'b1;
    force_resp = 1'b1;
    @(posedge clk); #3;
    force_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_req_ready", 32'(req_ready), 32'd1);
      chk("stray_mem_read", 32'(mem_read), 32'd0);
    end
    auto_mem = 1'b1;
    quiet    = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (i % 4 == 0) a[1:0] = 2'b00;
      issue(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
